regfile_access_engine: RTL and testbench

Sequential debug/bulk-access engine that sits on the CPU register file's ports: it walks an inclusive address range and either streams register contents out (dump) or streams words in and writes them (load). It drives one read address and the write port (WE3/A3/WD3) of the register file, holds the core stalled via `halt_req` while active, and talks to the debug link through valid/ready handshakes. One clock; reset is synchronous and active-high.

---
 rtl/regfile_access_engine.sv | 152 +++++++++++++++
 tb/tb_regfile_access_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_engine.sv
// Bulk debug access engine for the CPU register file: walks an inclusive,
// wrapping address range and either dumps register contents or loads new ones.
module regfile_access_engine #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] first_addr,
  input  logic [N-1:0] last_addr,
  output logic [N-1:0] rf_addr,
  input  logic [M-1:0] rf_rdata,
  output logic         rf_we,
  output logic [N-1:0] rf_waddr,
  output logic [M-1:0] rf_wdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic [N-1:0] out_addr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  output logic         busy,
  output logic         done,
  output logic         halt_req
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD      = 3'd1;
  localparam logic [2:0] SEND    = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] WR      = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]   state;
  logic [N-1:0] cur;
  logic [N-1:0] last_q;
  logic [M-1:0] dump_data_q;
  logic [N-1:0] dump_addr_q;
  logic [M-1:0] wr_data_q;
  logic [N-1:0] wr_addr_q;

  logic at_last;
  assign at_last = (cur == last_q);

  // cur wraps naturally at 2^N, so last < first walks through the top of the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      last_q      <= '0;
      dump_data_q <= '0;
      dump_addr_q <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur    <= first_addr;
            last_q <= last_addr;
            state  <= mode ? WR_WAIT : RD;
          end
        end
        RD: begin
          dump_data_q <= rf_rdata;
          dump_addr_q <= cur;
          state       <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (at_last) begin
              state <= DONE;
            end else begin
              cur   <= cur + 1'b1;
              state <= RD;
            end
          end
        end
        WR_WAIT: begin
          if (in_valid) begin
            wr_data_q <= in_data;
            wr_addr_q <= cur;
            state     <= WR;
          end
        end
        WR: begin
          if (at_last) begin
            state <= DONE;
          end else begin
            cur   <= cur + 1'b1;
            state <= WR_WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Every output is a decode of registered state, so no input reaches an output combinationally.
  always_comb begin
    rf_addr   = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RD: begin
        rf_addr = cur;
        busy    = 1'b1;
      end
      SEND: begin
        rf_addr   = cur;
        out_valid = 1'b1;
        out_data  = dump_data_q;
        out_addr  = dump_addr_q;
        busy      = 1'b1;
      end
      WR_WAIT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WR: begin
        rf_we    = 1'b1;
        rf_waddr = wr_addr_q;
        rf_wdata = wr_data_q;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign halt_req = busy;

endmodule

// File: tb/tb_regfile_access_engine.sv
// Scoreboard bench for regfile_access_engine: a behavioural register file sits on
// the engine's ports and expected dump words / writes are queued as operations start.
module tb_regfile_access_engine;

  localparam int N     = 4;
  localparam int M     = 32;
  localparam int DEPTH = 1 << N;

  typedef struct packed {
    logic [N-1:0] addr;
    logic [M-1:0] data;
  } word_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [N-1:0] first_addr;
  logic [N-1:0] last_addr;
  logic [N-1:0] rf_addr;
  logic [M-1:0] rf_rdata;
  logic         rf_we;
  logic [N-1:0] rf_waddr;
  logic [M-1:0] rf_wdata;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_data;
  logic [N-1:0] out_addr;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_data;
  logic         busy;
  logic         done;
  logic         halt_req;

  logic [M-1:0] rf_mem [DEPTH];
  logic [M-1:0] exp_rf [DEPTH];
  logic         pre_we;
  logic [N-1:0] pre_addr;
  logic [M-1:0] pre_data;

  word_t        dump_q [$];
  word_t        wr_q [$];
  logic [M-1:0] load_words [$];
  word_t        mon_w;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  regfile_access_engine #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rf_addr   (rf_addr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .halt_req  (halt_req)
  );

  // Behavioural register file: combinational read, write on the rising edge.
  assign rf_rdata = rf_mem[rf_addr];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    else if (pre_we) rf_mem[pre_addr] <= pre_data;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Monitor: pops expectations on each dump handshake and each write strobe.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
      checkOutput("halt_eq_busy", 64'(halt_req), 64'(busy));
      if (out_valid && out_ready) begin
        checkOutput("dump_expected", 64'(dump_q.size() != 0), 64'd1);
        if (dump_q.size() != 0) begin
          mon_w = dump_q.pop_front();
          checkOutput("dump_addr", 64'(out_addr), 64'(mon_w.addr));
          checkOutput("dump_data", 64'(out_data), 64'(mon_w.data));
        end
      end
      if (rf_we) begin
        checkOutput("write_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          mon_w = wr_q.pop_front();
          checkOutput("write_addr", 64'(rf_waddr), 64'(mon_w.addr));
          checkOutput("write_data", 64'(rf_wdata), 64'(mon_w.data));
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_data"}, {out_data, rf_wdata}, 64'd0);
    checkOutput({tag, "_ctrl"},
                64'({rf_addr, rf_waddr, out_addr, rf_we, out_valid, in_ready, busy, done, halt_req}),
                64'd0);
  endtask

  // Queues the expected effect of an operation, then pulses start for one edge.
  task automatic applyStimulus(input logic m, input logic [N-1:0] f, input logic [N-1:0] l);
    logic [N-1:0] span;
    logic [N-1:0] a;
    int count;
    span  = l - f;
    count = int'(span) + 1;
    a     = f;
    for (int k = 0; k < count; k++) begin
      if (m) begin
        wr_q.push_back('{addr: a, data: load_words[k]});
        exp_rf[a] = load_words[k];
      end else begin
        dump_q.push_back('{addr: a, data: exp_rf[a]});
      end
      a = a + 1'b1;
    end
    @(posedge clk); #1;
    start      = 1'b1;
    mode       = m;
    first_addr = f;
    last_addr  = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic driveLoad();
    int n;
    for (int k = 0; k < load_words.size(); k++) begin
      in_data  = load_words[k];
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("in_ready_seen", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    checkOutput("dump_q_drained", 64'(dump_q.size()), 64'd0);
    checkOutput("wr_q_drained", 64'(wr_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    out_ready  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // R[i] = 0x11 * (i + 1), so R0..R3 hold 0x11..0x44.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      pre_we    = 1'b1;
      pre_addr  = N'(i);
      pre_data  = 32'h11 * (i + 1);
      exp_rf[i] = 32'h11 * (i + 1);
    end
    @(posedge clk); #1;
    pre_we = 1'b0;

    $display("[TB] reset in the middle of a dump");
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd15);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    dump_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("mid_dump_reset");

    $display("[TB] dump 0..3 with cycle timing");
    applyStimulus(1'b0, 4'd0, 4'd3);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checkOutput($sformatf("dump_valid_cycle%0d", c), 64'(out_valid), 64'((c % 2 == 0) && (c <= 8)));
      checkOutput($sformatf("dump_done_cycle%0d", c), 64'(done), 64'(c == 9));
    end
    checkOutput("timed_dump_drained", 64'(dump_q.size()), 64'd0);
    @(posedge clk); #1;

    $display("[TB] dump 2..4 with backpressure on the second word");
    out_ready = 1'b0;
    applyStimulus(1'b0, 4'd2, 4'd4);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_first_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_data", 64'(out_data), 64'(exp_rf[3]));
      checkOutput("bp_hold_addr", 64'(out_addr), 64'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitDone(50);

    $display("[TB] wrapping load 14..1");
    load_words.delete();
    load_words.push_back(32'hA);
    load_words.push_back(32'hB);
    load_words.push_back(32'hC);
    load_words.push_back(32'hD);
    applyStimulus(1'b1, 4'd14, 4'd1);
    driveLoad();
    waitDone(20);

    $display("[TB] dump 14..1 reads back the loaded words");
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd14, 4'd1);
    waitDone(50);

    $display("[TB] single-word and full-range dumps");
    applyStimulus(1'b0, 4'd5, 4'd5);
    waitDone(20);
    applyStimulus(1'b0, 4'd3, 4'd2);
    waitDone(100);

    $display("[TB] start pulse during a dump is ignored");
    applyStimulus(1'b0, 4'd0, 4'd3);
    @(posedge clk); #1;
    start      = 1'b1;
    mode       = 1'b1;
    first_addr = 4'd7;
    last_addr  = 4'd9;
    in_valid   = 1'b1;
    in_data    = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    waitDone(50);
    @(negedge clk);
    checkIdleOutputs("after_ignored_start");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
